// File: rtl/ahb_to_fpga_sram.sv
// AHB-Lite slave bridging to a single-port synchronous FPGA SRAM through a one-entry write buffer.
// Optional macro AHB_SRAM_RAW_FWD_EN: forward buffered bytes to matching reads instead of stalling them.
module ahb_to_fpga_sram #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          HRESP,
  input  logic [31:0]   SRAMRDATA,
  output logic [AW-3:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS
);

  typedef enum logic {ST_IDLE = 1'b0, ST_STALL = 1'b1} state_t;

  state_t        r_state;
  logic          r_hreadyout;
  logic          r_rd_dphase;
  logic          r_wr_pend;
  logic          r_buf_valid;
  logic [AW-3:0] r_stall_addr;
  logic [AW-3:0] r_wr_addr;
  logic [AW-3:0] r_buf_addr;
  logic [3:0]    r_wr_lanes;
  logic [3:0]    r_buf_lanes;
  logic [31:0]   r_buf_data;

  logic          w_accept;
  logic          w_rd_req;
  logic          w_wr_req;
  logic [AW-3:0] w_addr_word;
  logic [3:0]    w_lanes;
  logic          w_load;
  logic          w_hit_buf;
  logic          w_hit_pend;
  logic          w_conflict;
  logic          w_rd_stall;
  logic          w_stall_hit;
  logic          w_rd_issue;
  logic          w_drain;
  logic          w_wt;
  logic [31:0]   w_rd_data;
  logic          w_unused;

  assign w_unused    = HTRANS[0];
  assign w_accept    = HSEL & HTRANS[1] & HREADY;
  assign w_rd_req    = w_accept & ~HWRITE & (r_state == ST_IDLE);
  assign w_wr_req    = w_accept & HWRITE;
  assign w_addr_word = HADDR[AW-1:2];
  assign w_load      = r_wr_pend & HREADY;
  assign w_hit_buf   = r_buf_valid & (r_buf_addr == w_addr_word);
  assign w_hit_pend  = r_wr_pend & (r_wr_addr == w_addr_word);
  // Buffer full while its successor is about to load: the old entry must leave now.
  assign w_conflict  = r_buf_valid & w_load;

  always_comb begin
    case (HSIZE)
      3'd0:    w_lanes = 4'b0001 << HADDR[1:0];
      3'd1:    w_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
      default: w_lanes = 4'b1111;
    endcase
  end

`ifdef AHB_SRAM_RAW_FWD_EN
  logic [AW-3:0] r_rd_addr;
  logic          w_fwd_hit;

  assign w_rd_stall  = w_rd_req & w_conflict;
  assign w_stall_hit = 1'b0;
  assign w_fwd_hit   = r_buf_valid & (r_buf_addr == r_rd_addr);

  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign w_rd_data[8*gi +: 8] = (w_fwd_hit && r_buf_lanes[gi]) ?
                                  r_buf_data[8*gi +: 8] : SRAMRDATA[8*gi +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (w_rd_issue) r_rd_addr <= SRAMADDR;
  end
`else
  assign w_rd_stall  = w_rd_req & (w_conflict | w_hit_buf | w_hit_pend);
  assign w_stall_hit = r_buf_valid & (r_buf_addr == r_stall_addr);
  assign w_rd_data   = SRAMRDATA;
`endif

  assign HRDATA    = r_rd_dphase ? w_rd_data : 32'h0;
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = 1'b0;

  // SRAM port arbitration; everything is gated during reset so a buffered write dies with it.
  always_comb begin
    SRAMCS     = 1'b0;
    SRAMWEN    = 4'h0;
    SRAMADDR   = w_addr_word;
    SRAMWDATA  = r_buf_data;
    w_rd_issue = 1'b0;
    w_drain    = 1'b0;
    w_wt       = 1'b0;
    if (HRESETn) begin
      if (r_state == ST_STALL) begin
        SRAMCS = 1'b1;
        if (w_stall_hit) begin
          SRAMWEN  = r_buf_lanes;
          SRAMADDR = r_buf_addr;
          w_drain  = 1'b1;
        end else begin
          SRAMADDR   = r_stall_addr;
          w_rd_issue = 1'b1;
        end
      end else if (w_rd_req && !w_rd_stall) begin
        SRAMCS     = 1'b1;
        w_rd_issue = 1'b1;
      end else if (r_buf_valid) begin
        SRAMCS   = 1'b1;
        SRAMWEN  = r_buf_lanes;
        SRAMADDR = r_buf_addr;
        w_drain  = 1'b1;
      end else if (w_rd_stall) begin
        // Empty buffer, read hits the write in its data phase: write it straight through.
        SRAMCS    = 1'b1;
        SRAMWEN   = r_wr_lanes;
        SRAMADDR  = r_wr_addr;
        SRAMWDATA = HWDATA;
        w_wt      = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_rd_dphase <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_buf_valid <= 1'b0;
    end else begin
      r_rd_dphase <= w_rd_issue;
      if (HREADY) begin
        r_wr_pend <= w_wr_req;
        if (w_wr_req) begin
          r_wr_addr  <= w_addr_word;
          r_wr_lanes <= w_lanes;
        end
      end
      if (w_load && !w_wt) begin
        r_buf_valid <= 1'b1;
        r_buf_addr  <= r_wr_addr;
        r_buf_lanes <= r_wr_lanes;
        r_buf_data  <= HWDATA;
      end else if (w_drain) begin
        r_buf_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_rd_stall) begin
            r_state      <= ST_STALL;
            r_stall_addr <= w_addr_word;
            r_hreadyout  <= 1'b0;
          end
        end
        ST_STALL: begin
          if (!w_stall_hit) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
